feedback_shift_bank: RTL
========================

FEEDBACK_SHIFT_BANK -- requirements
Module: feedback_shift_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 13, bit width of one GF(2^13) symbol per stage.
REQ-002 SHALL have parameter DEPTH, default 8, number of register stages; legal range 2..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  WIDTH  symbol shifted into stage 0 in LOAD mode.
REQ-006 SHALL have port mode  input  2  operation select: 00 HOLD, 01 LOAD, 10 ROTATE, 11 CLEAR.
REQ-007 SHALL have port qout  output  WIDTH  contents of stage DEPTH-1.
REQ-008 SHALL have port q_all  output  WIDTH*DEPTH  all stages flattened, stage i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port full  output  1  high once DEPTH symbols have been loaded since the last clear or reset.
REQ-010 SHALL have port rev_done  output  1  registered one-cycle pulse at completion of one full revolution.
REQ-011 SHALL have port all_zero  output  1  combinational, high when every stage equals 0.

Function
REQ-012 HOLD SHALL keep every stage, both counters and full unchanged; rev_done SHALL be 0.
REQ-013 LOAD SHALL set stage[0]<=din and stage[i]<=stage[i-1] for i=1..DEPTH-1, discarding the old stage[DEPTH-1].
REQ-014 LOAD SHALL increment load_cnt (width clog2(DEPTH+1)), saturating at DEPTH; full SHALL equal (load_cnt==DEPTH) as a registered value.
REQ-015 LOAD SHALL clear rot_cnt to 0.
REQ-016 ROTATE with full=1 SHALL set stage[0]<=stage[DEPTH-1] and stage[i]<=stage[i-1]; no data is lost.
REQ-017 ROTATE with full=1 SHALL increment rot_cnt modulo DEPTH; on the wrap DEPTH-1->0, rev_done SHALL be 1 in the following cycle only.
REQ-018 ROTATE with full=0 SHALL behave as HOLD: no shift, no count, and rev_done=0.
REQ-019 CLEAR SHALL zero all stages, load_cnt and rot_cnt, and full, in one cycle; rev_done SHALL be 0.
REQ-020 A mode change away from ROTATE SHALL retain rot_cnt, so that a later resumed ROTATE completes the same revolution.
REQ-021 qout and q_all SHALL reflect register state directly, with no additional pipeline stage; there is no latency beyond the one clock edge.
REQ-022 After exactly DEPTH ROTATE cycles, stage contents SHALL equal their contents before the first of those cycles.

Reset
REQ-023 While reset=0, all stages, load_cnt, rot_cnt, full and rev_done SHALL be 0, asynchronously and independent of clk.
REQ-024 Reset asserted mid-LOAD or mid-ROTATE SHALL abort the operation with no residual count; the first edge after release SHALL obey mode.
REQ-025 Reset release SHALL be synchronised externally; the block SHALL NOT add a synchroniser.

Structure
REQ-026 Mode encodings (MODE_HOLD, MODE_LOAD, MODE_ROTATE, MODE_CLEAR) SHALL live in the shared decoder package; WIDTH and DEPTH stay module parameters.
REQ-027 One sub-module fb_stage SHALL be used per stage: a WIDTH-bit register with async active-low reset and a 3:1 next-value mux (hold, shift-in, zero).
REQ-028 The counters, full and rev_done logic SHALL reside in the top level; no FSM beyond the counters is required.

Verification (bench uses WIDTH=13, DEPTH=4)
REQ-029 Reset, then LOAD din=0x001,0x002,0x003,0x004 -> q_all stage0..3 = 0x004,0x003,0x002,0x001; full=1 after 4th edge; qout=0x001.
REQ-030 Full bank, ROTATE for 4 cycles -> qout sequence 0x002,0x003,0x004,0x001; rev_done=1 only in the cycle after the 4th edge; q_all matches the pre-rotate value.
REQ-031 ROTATE 2 cycles, HOLD 3 cycles, ROTATE 2 cycles -> rev_done pulses once, after the final edge; q_all matches the pre-rotate value.
REQ-032 Load 2 symbols (full=0), then ROTATE 3 cycles -> stages unchanged, rev_done stays 0; a 5th LOAD on a full bank drops the oldest symbol and full stays 1.
REQ-033 Full bank, assert reset mid-rotation between edges -> all outputs 0 immediately; all_zero=1; CLEAR on a loaded bank gives the same result at the next edge.

Source files
------------

// File: rtl/feedback_shift_bank_pkg.sv
// Shared decode values for the feedback shift bank: operating modes and per-stage mux selects.
package feedback_shift_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_SHIFT = 2'b01,
        SEL_ZERO  = 2'b10
    } stage_sel_e;

endpackage

// File: rtl/fb_stage.sv
// One symbol register of the bank: keep, take the shift-in value, or zero.
// Latency: one clock edge. No backpressure; the next value is chosen by sel_i every cycle.
module fb_stage
    import feedback_shift_bank_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  stage_sel_e       sel_i,
    input  logic [WIDTH-1:0] shift_dat_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        case (sel_i)
            SEL_SHIFT: data_d = shift_dat_i;
            SEL_ZERO:  data_d = '0;
            default:   data_d = data_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) data_q <= '0;
        else          data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/feedback_shift_bank.sv
// Bank of DEPTH GF(2^13) symbol registers that loads serially and rotates in a closed loop.
// Latency: outputs are the registers themselves. No backpressure; ROTATE is ignored until the bank is full.
module feedback_shift_bank
    import feedback_shift_bank_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic [1:0]             mode,
    output logic [WIDTH-1:0]       qout,
    output logic [WIDTH*DEPTH-1:0] q_all,
    output logic                   full,
    output logic                   rev_done,
    output logic                   all_zero
);

    localparam int LCW = $clog2(DEPTH + 1);
    localparam int RCW = $clog2(DEPTH);
    localparam logic [LCW-1:0] LOAD_MAX = LCW'(DEPTH);
    localparam logic [RCW-1:0] ROT_LAST = RCW'(DEPTH - 1);

    mode_e            mode_sel;
    stage_sel_e       stage_sel;
    logic [LCW-1:0]   load_cnt_q, load_cnt_d;
    logic [RCW-1:0]   rot_cnt_q, rot_cnt_d;
    logic             full_q, full_d;
    logic             rev_done_q, rev_done_d;
    logic [WIDTH-1:0] stage_q [DEPTH];

    assign mode_sel = mode_e'(mode);

    // rot_cnt survives HOLD/ROTATE-while-not-full so an interrupted revolution resumes where it left off.
    always_comb begin
        stage_sel  = SEL_HOLD;
        load_cnt_d = load_cnt_q;
        rot_cnt_d  = rot_cnt_q;
        rev_done_d = 1'b0;
        case (mode_sel)
            MODE_LOAD: begin
                stage_sel = SEL_SHIFT;
                if (load_cnt_q != LOAD_MAX) load_cnt_d = load_cnt_q + LCW'(1);
                rot_cnt_d = '0;
            end
            MODE_ROTATE: begin
                if (full_q) begin
                    stage_sel  = SEL_SHIFT;
                    rev_done_d = (rot_cnt_q == ROT_LAST);
                    rot_cnt_d  = (rot_cnt_q == ROT_LAST) ? '0 : rot_cnt_q + RCW'(1);
                end
            end
            MODE_CLEAR: begin
                stage_sel  = SEL_ZERO;
                load_cnt_d = '0;
                rot_cnt_d  = '0;
            end
            default: stage_sel = SEL_HOLD;
        endcase
        full_d = (load_cnt_d == LOAD_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_q <= '0;
            rot_cnt_q  <= '0;
            full_q     <= 1'b0;
            rev_done_q <= 1'b0;
        end else begin
            load_cnt_q <= load_cnt_d;
            rot_cnt_q  <= rot_cnt_d;
            full_q     <= full_d;
            rev_done_q <= rev_done_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] shift_dat;
        if (i == 0) begin : g_head
            // Stage 0 takes new data in LOAD and the tail symbol in ROTATE.
            assign shift_dat = (mode_sel == MODE_LOAD) ? din : stage_q[DEPTH-1];
        end else begin : g_body
            assign shift_dat = stage_q[i-1];
        end

        fb_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i       (clk),
            .rst_n_i     (reset),
            .sel_i       (stage_sel),
            .shift_dat_i (shift_dat),
            .q_o         (stage_q[i])
        );

        assign q_all[i*WIDTH +: WIDTH] = stage_q[i];
    end

    assign qout     = stage_q[DEPTH-1];
    assign full     = full_q;
    assign rev_done = rev_done_q;
    assign all_zero = (q_all == '0);

endmodule
